// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array datapath: hold-stage state encoding
// and elaboration-time helpers for shift width, counter width and saturation.
package sa_pkg;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    function automatic int shift_width(input int wy);
        return (wy > 1) ? $clog2(wy) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint sat_max(input int wq);
        return (longint'(1) << (wq - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int wq);
        return -(longint'(1) << (wq - 1));
    endfunction

endpackage

// File: rtl/axis_out_pack_requant.sv
// One-element requantizer: optional ReLU, round-half-up arithmetic right shift,
// then signed saturation from WY to WQ bits.
module requant
    import sa_pkg::*;
#(
    parameter int WY = 16,
    parameter int WQ = 8,
    parameter int SW = 4
) (
    input  logic signed [WY-1:0] v,
    input  logic [SW-1:0]        shift,
    input  logic                 relu,
    output logic signed [WQ-1:0] q
);

    localparam logic signed [WY:0] QMAX = (WY+1)'(sat_max(WQ));
    localparam logic signed [WY:0] QMIN = (WY+1)'(sat_min(WQ));

    logic signed [WY:0] v_ext;
    logic signed [WY:0] rnd;
    logic signed [WY:0] sum;
    logic signed [WY:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        v_ext = (relu && v[WY-1]) ? '0 : {v[WY-1], v};
        rnd = '0;
        if (shift != '0) begin
            rnd = $signed((WY+1)'(1) << (shift - SW'(1)));
        end
        sum     = v_ext + rnd;
        shifted = sum >>> shift;
        if (shifted > QMAX) begin
            q = QMAX[WQ-1:0];
        end else if (shifted < QMIN) begin
            q = QMIN[WQ-1:0];
        end else begin
            q = shifted[WQ-1:0];
        end
    end

endmodule

// File: rtl/axis_out_pack.sv
// Array output stage: requantizes R wide row results per input beat and
// serializes them into R/P narrow AXI-stream beats, preserving tile TLAST.
//
// state      | meaning
// HOLD_EMPTY | no input beat held; s_ready follows rstn
// HOLD_FULL  | beat held; cnt_q selects the next sub-beat to load into output
module axis_out_pack
    import sa_pkg::*;
#(
    parameter int R  = 4,
    parameter int WY = 16,
    parameter int P  = 2,
    parameter int WQ = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [R-1:0][WY-1:0]    s_data,
    input  logic [$clog2(WY)-1:0]   cfg_shift,
    input  logic                    cfg_relu,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [P-1:0][WQ-1:0]    m_data
);

    localparam int N  = R / P;
    localparam int SW = shift_width(WY);
    localparam int CW = cnt_width(N);

    hold_state_e             state_q;
    logic [R-1:0][WY-1:0]    hold_data_q;
    logic                    hold_last_q;
    logic                    hold_relu_q;
    logic [SW-1:0]           hold_shift_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic [P-1:0][WQ-1:0]    m_data_q;
    logic                    m_last_q;
    logic                    m_valid_q;

    logic                    hold_v;
    logic                    last_sub;
    logic                    load;
    logic                    accept;
    logic [P-1:0][WY-1:0]    lane_v;
    logic [P-1:0][WQ-1:0]    q_lane;

    assign hold_v   = (state_q == HOLD_FULL);
    assign last_sub = (cnt_q == CW'(N - 1));
    assign load     = hold_v && (!m_valid_q || m_ready);
    // Accepting while the final sub-beat leaves avoids a bubble between beats.
    assign s_ready  = rstn && (!hold_v || (load && last_sub));
    assign accept   = s_valid && s_ready;
    assign cnt_d    = last_sub ? '0 : cnt_q + CW'(1);

    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = m_data_q;

    always_comb begin
        lane_v = '0;
        for (int p = 0; p < P; p++) begin
            lane_v[p] = hold_data_q[int'(cnt_q) * P + p];
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        requant #(
            .WY(WY),
            .WQ(WQ),
            .SW(SW)
        ) u_requant (
            .v     (lane_v[p]),
            .shift (hold_shift_q),
            .relu  (hold_relu_q),
            .q     (q_lane[p])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= HOLD_EMPTY;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_relu_q  <= 1'b0;
            hold_shift_q <= '0;
            cnt_q        <= '0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                HOLD_EMPTY: if (accept) state_q <= HOLD_FULL;
                HOLD_FULL:  if (load && last_sub && !accept) state_q <= HOLD_EMPTY;
            endcase

            if (accept) begin
                hold_data_q  <= s_data;
                hold_last_q  <= s_last;
                hold_relu_q  <= cfg_relu;
                hold_shift_q <= cfg_shift;
                cnt_q        <= '0;
            end else if (load) begin
                cnt_q <= cnt_d;
            end

            if (load) begin
                m_data_q  <= q_lane;
                m_last_q  <= hold_last_q && last_sub;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axis_out_pack.md
# axis_out_pack

Output stage placed directly after the systolic array. Each accepted array beat carries R accumulated WY-bit row results. The block requantizes them (optional ReLU, rounding arithmetic right shift, signed saturation to WQ bits) and serializes them into R/P narrower AXI-stream beats of P lanes each. TLAST is preserved so that tile boundaries from the array survive the width change.

## Interface
- R, default 4: rows per input beat; must equal the array's R.
- WY, default 16: signed input element width.
- P, default 2: lanes per output beat; R % P == 0 is required.
- WQ, default 8: signed output element width; WQ ≤ WY.
- N (localparam): R/P, the number of output beats per input beat.
- clk, in, 1: clock.
- rstn, in, 1: reset; synchronous, active-low.
- s_valid, in, 1: input beat valid.
- s_ready, out, 1: input beat ready.
- s_last, in, 1: last beat of a tile.
- s_data, in, [R-1:0][WY-1:0]: signed row results.
- cfg_shift, in, $clog2(WY): right-shift amount; sampled on input accept.
- cfg_relu, in, 1: clamp negatives to 0; sampled on input accept.
- m_valid, out, 1: output beat valid.
- m_ready, in, 1: output beat ready.
- m_last, out, 1: last output beat of a tile.
- m_data, out, [P-1:0][WQ-1:0]: requantized lanes.

## Operation
- The block has two stages.
  - Hold stage: a one-beat register (hold_data, hold_last, hold_shift, hold_relu, hold_v) plus a sub-beat counter cnt in 0..N-1.
  - Output stage: a registered m_data/m_last/m_valid.
- Hold-stage states:
  - EMPTY (hold_v=0) → FULL on s_valid && s_ready. Both cnt and the cfg snapshot are captured then.
  - FULL → EMPTY when the cnt==N-1 sub-beat loads into the output stage and no new beat is accepted in the same cycle. Otherwise it stays FULL with the new beat and cnt=0.
- Output load: load = hold_v && (!m_valid || m_ready).
  - On load, lane p of m_data = quant(hold_data[cnt*P+p]), and m_last = hold_last && cnt==N-1.
  - cnt increments on load and wraps to 0 after N-1.
- s_ready = rstn && (!hold_v || (load && cnt==N-1)). The next beat is accepted in the same cycle the final sub-beat leaves, so there is no bubble.
- If m_valid && m_ready && !load, m_valid clears to 0.
- quant(v) is computed on WY+1 signed bits:
  - If relu && v<0, v=0.
  - Add 2^(shift-1) when shift>0, then arithmetic shift right by shift.
  - Saturate to [-2^(WQ-1), 2^(WQ-1)-1].
- Output order within an input beat is ascending row (row 0 in lane 0 of the first output beat).
- s_last=0 beats never produce m_last.

## Timing
- Reset values: m_valid=0, m_last=0, m_data=0, hold_v=0, cnt=0. s_ready=0 while rstn=0, and 1 in the first cycle after release.
- Latency: input accepted at edge k → first sub-beat has m_valid=1 after edge k+1.
- Throughput: with m_ready held at 1, there is one output beat per cycle and one input beat accepted every N cycles.
- m_data and m_last are held stable while m_valid && !m_ready (AXI rule).
- Simultaneous final-sub-beat load and new accept: the new beat overwrites hold, and cnt resets to 0.
- cfg changes during FULL have no effect until the next accept.
- Reset mid-tile: partial sub-beats are discarded; no m_last is emitted for the aborted tile.

## Structure
- Add to shared package sa_pkg: a function for the saturation bounds, and a clog2-based localparam helper for the shift width.
- Sub-module requant (combinational, one element): ports v, shift, relu → q. Instantiate P of them, fed by the hold-stage mux on cnt.

## Test plan
- Requantize and serialize one beat: R=4, P=2, WQ=8, shift=0, relu=0, s_data={100,-3,300,-300}, s_last=1, m_ready=1 → required response:
  - beat 1: {100,-3}, m_last=0;
  - beat 2: {127,-128}, m_last=1.
- Rounding: shift=2, s_data={5,6,-5,-6} → {1,2} then {-1,-1}.
- ReLU: relu=1, s_data={-7,7,0,-32768} → {0,7} then {0,0}.
- Streaming at full throughput: 8 beats with continuous s_valid and m_ready=1 → required response:
  - 16 output beats in 16 consecutive cycles;
  - s_ready pattern 1,0,1,0,…;
  - m_last only on output beats from s_last beats.
- Backpressure: m_ready toggles 1,0,1,0 over 3 beats → required response:
  - order preserved;
  - m_data stable during stall cycles;
  - no beat lost or duplicated;
  - s_ready never high while an unsent sub-beat remains.
- Reset mid-tile: assert rstn=0 after the first sub-beat of a beat → required response:
  - m_valid=0 the next cycle;
  - after release, the first output is lanes 0..P-1 of the next accepted beat.
